// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage req/ack data-memory controller with pipeline stall, misalignment and timeout faults.
// Optional byte access (LDURB/STURB) is enabled by defining MEM_BYTE_ACCESS_EN.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] mem_ALU_result,
    input  logic [63:0] mem_write_data,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
`ifdef MEM_BYTE_ACCESS_EN
    input  logic        mem_byte,
`endif
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata,
    output logic [63:0] mem_read_data,
    output logic        mem_stall,
    output logic        mem_fault
);
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
    logic [1:0]  state;
    logic [7:0]  cnt;
    logic        acc, aligned, timeout;
    logic [63:0] wdata_n, ld_data;
    assign acc     = mem_read_en | mem_write_en;
    assign timeout = cnt == 8'(TIMEOUT_CYCLES - 1);
`ifdef MEM_BYTE_ACCESS_EN
    logic byte_q;
    assign aligned = mem_byte | (mem_ALU_result[2:0] == 3'd0);
    assign wdata_n = mem_byte ? {8{mem_write_data[7:0]}} : mem_write_data;
    assign ld_data = byte_q ? {56'b0, dmem_rdata[8*dmem_addr[2:0] +: 8]} : dmem_rdata;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            byte_q  <= 1'b0;
            dmem_be <= 8'hFF;
        end else if (state == IDLE && acc && aligned) begin
            byte_q  <= mem_byte;
            dmem_be <= mem_byte ? 8'd1 << mem_ALU_result[2:0] : 8'hFF;
        end
`else
    assign aligned = mem_ALU_result[2:0] == 3'd0;
    assign wdata_n = mem_write_data;
    assign ld_data = dmem_rdata;
    assign dmem_be = 8'hFF;
`endif
    // Stall is combinational in IDLE so the issuing cycle itself holds the pipeline.
    assign mem_stall = (state == BUSY) | (state == IDLE & acc & aligned);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= 64'd0;
            dmem_wdata    <= 64'd0;
            mem_read_data <= 64'd0;
            mem_fault     <= 1'b0;
        end else begin
            mem_fault <= 1'b0;
            cnt       <= state == BUSY ? cnt + 8'd1 : 8'd0;
            case (state)
                IDLE:
                    if (acc && aligned) begin
                        state      <= BUSY;
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_write_en;
                        dmem_addr  <= mem_ALU_result;
                        dmem_wdata <= wdata_n;
                    end else if (acc) begin
                        mem_fault <= 1'b1;
                        if (!mem_write_en) mem_read_data <= 64'd0;
                    end
                BUSY:
                    // Ack has priority over a coincident timeout.
                    if (dmem_ack) begin
                        if (!dmem_we) mem_read_data <= ld_data;
                        dmem_req <= 1'b0;
                        state    <= DONE;
                    end else if (timeout) begin
                        if (!dmem_we) mem_read_data <= 64'd0;
                        dmem_req  <= 1'b0;
                        mem_fault <= 1'b1;
                        state     <= DONE;
                    end
                default: state <= IDLE;
            endcase
        end
endmodule
